ex_div_iter: RTL

- Parametrised multi-cycle integer divider; slave side of the ex_div handshake (dividend, divisor, op, start / is_running, quotient_out, remainder_out, done).
- Sits beside the EX-stage ALU and serves LoongArch div.w, mod.w, div.wu and mod.wu.
- Successor to the fixed 32-bit radix-2 divider, with:
  - configurable operand width;
  - configurable quotient bits retired per cycle;
  - a one-cycle divide-by-zero fast path;
  - a pipeline-flush cancel input.

---
 rtl/ex_div_iter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ex_div_iter.sv
// ex_div_iter: multi-cycle restoring integer divider for the EX stage.
// It serves div.w/mod.w/div.wu/mod.wu and always produces both the quotient
// and the remainder. It retires BITS_PER_CYCLE quotient bits per cycle, takes
// a one-cycle fast path on a zero divisor, and can be cancelled by a pipeline flush.
module ex_div_iter #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             is_running,
   output logic             done,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out
);

   localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state_q;
   state_t           state_n;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dsr_q;
   logic             neg_quo_q;
   logic             neg_rem_q;

   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;
   logic [WIDTH:0]   trial;

   logic             accept;
   logic             op_signed;
   logic             dvd_neg;
   logic             dsr_neg;
   logic             dsr_zero;
   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dsr_abs;

   // op[0] (div vs mod) only matters to the consumer; both results are produced.
   logic             op_mod_unused;
   assign op_mod_unused = op[0];

   // Request decode and operand magnitudes; abs(MIN) stays 2^(WIDTH-1) as unsigned.
   always_comb begin
      accept    = (state_q == S_IDLE) && start && !flush;
      op_signed = ~op[1];
      dvd_neg   = op_signed & dividend[WIDTH-1];
      dsr_neg   = op_signed & divisor[WIDTH-1];
      dsr_zero  = (divisor == '0);
      dvd_abs   = dvd_neg ? -dividend : dividend;
      dsr_abs   = dsr_neg ? -divisor : divisor;
   end

   // BITS_PER_CYCLE restoring shift-subtract steps; the quotient register
   // doubles as the dividend shifter, with quotient bits entering at the LSB.
   always_comb begin
      rem_n = rem_q;
      quo_n = quo_q;
      trial = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         trial = {rem_n, quo_n[WIDTH-1]};
         quo_n = quo_n << 1;
         if (trial >= {1'b0, dsr_q}) begin
            trial    = trial - {1'b0, dsr_q};
            quo_n[0] = 1'b1;
         end
         rem_n = trial[WIDTH-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic; flush returns any busy state to IDLE.
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_n = dsr_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_n = S_IDLE;
            end else if (cnt_q == CW'(1)) begin
               state_n = S_FIX;
            end
         end
         S_FIX: begin
            state_n = flush ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Status outputs decode directly from the registered state.
   always_comb begin
      done       = (state_q == S_DONE);
      is_running = (state_q != S_IDLE);
   end

   // Datapath: operand capture, iteration, sign fix-up and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dsr_q         <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         quotient_out  <= '0;
         remainder_out <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  rem_q     <= '0;
                  quo_q     <= dvd_abs;
                  dsr_q     <= dsr_abs;
                  neg_quo_q <= dvd_neg ^ dsr_neg;
                  neg_rem_q <= dvd_neg;
                  if (dsr_zero) begin
                     quotient_out  <= '1;
                     remainder_out <= dividend;
                  end else begin
                     cnt_q <= CW'(ITER);
                  end
               end
            end
            S_CALC: begin
               if (flush) begin
                  cnt_q <= '0;
               end else begin
                  rem_q <= rem_n;
                  quo_q <= quo_n;
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_FIX: begin
               if (!flush) begin
                  quotient_out  <= neg_quo_q ? -quo_q : quo_q;
                  remainder_out <= neg_rem_q ? -rem_q : rem_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
